// File: rtl/alu4_acc.sv
// 4-bit accumulator ALU: single-cycle logic ops, bit-serial ADD/SUB.
// The accumulator and flags change only on completion; done pulses for one cycle.
module alu4_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] op,
  input  logic [3:0] operand,
  output logic [3:0] acc,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOGIC, SERIAL, DONE} state_t;
  typedef enum logic [2:0] {
    OP_LOAD, OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_ADD, OP_SUB, OP_NOT
  } op_t;

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [3:0] opb_q, opb_d;
  logic [1:0] cnt_q, cnt_d;
  logic       cy_q, cy_d;
  logic [3:0] sr_q, sr_d;
  logic [3:0] acc_q, acc_d;
  logic       c_q, c_d, n_q, n_d, z_q, z_d, v_q, v_d;

  logic       sum_bit, cout;
  logic [3:0] logic_res;

  // sr_q starts as a copy of A and shifts right: A bits leave at [0], sum bits enter at [3]
  assign sum_bit = sr_q[0] ^ opb_q[cnt_q] ^ cy_q;
  assign cout    = (sr_q[0] & opb_q[cnt_q]) | (cy_q & (sr_q[0] ^ opb_q[cnt_q]));

  always_comb begin
    logic_res = opb_q;
    case (op_q)
      OP_LOAD: logic_res = opb_q;
      OP_AND:  logic_res = acc_q & opb_q;
      OP_OR:   logic_res = acc_q | opb_q;
      OP_XOR:  logic_res = acc_q ^ opb_q;
      OP_XNOR: logic_res = ~(acc_q ^ opb_q);
      OP_NOT:  logic_res = ~acc_q;
      default: logic_res = opb_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    c_d     = c_q;
    n_d     = n_q;
    z_d     = z_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op_t'(op);
          opb_d = (op_t'(op) == OP_SUB) ? ~operand : operand;
          cnt_d = '0;
          cy_d  = (op_t'(op) == OP_SUB);
          sr_d  = acc_q;
          state_d = (op_t'(op) == OP_ADD || op_t'(op) == OP_SUB) ? SERIAL : LOGIC;
        end
      end
      LOGIC: begin
        acc_d   = logic_res;
        c_d     = 1'b0;
        v_d     = 1'b0;
        n_d     = logic_res[3];
        z_d     = (logic_res == 4'h0);
        state_d = DONE;
      end
      SERIAL: begin
        sr_d  = {sum_bit, sr_q[3:1]};
        cy_d  = cout;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          acc_d   = sr_d;
          c_d     = cout;
          v_d     = (acc_q[3] == opb_q[3]) && (sum_bit != acc_q[3]);
          n_d     = sum_bit;
          z_d     = (sr_d == 4'h0);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      opb_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sr_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == LOGIC) || (state_q == SERIAL);
  assign done     = (state_q == DONE);
  assign acc      = acc_q;
  assign c        = c_q;
  assign n        = n_q;
  assign z        = z_q;
  assign v        = v_q;

endmodule

// File: tb/tb_alu4_acc.sv
// Scoreboard bench for alu4_acc: expected results are queued at accept and
// compared when done pulses.
module tb_alu4_acc;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] operand;
  logic [3:0] acc;
  logic       c, n, z, v, done, busy;

  typedef struct {
    logic [3:0] acc;
    logic       c, n, z, v;
    int         lat;
    int         acyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_acc;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  alu4_acc dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .operand  (operand),
    .acc      (acc),
    .c        (c),
    .n        (n),
    .z        (z),
    .v        (v),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [2:0] o, input logic [3:0] b);
    exp_t       e;
    logic [4:0] s;
    e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acyc = 0;
    e.acc = b;
    case (o)
      3'd0: e.acc = b;
      3'd1: e.acc = a & b;
      3'd2: e.acc = a | b;
      3'd3: e.acc = a ^ b;
      3'd4: e.acc = ~(a ^ b);
      3'd5: begin
        s = {1'b0, a} + {1'b0, b};
        e.acc = s[3:0]; e.c = s[4]; e.lat = 4;
        e.v = (a[3] == b[3]) && (s[3] != a[3]);
      end
      3'd6: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        e.acc = s[3:0]; e.c = s[4]; e.lat = 4;
        e.v = (a[3] != b[3]) && (s[3] != a[3]);
      end
      default: e.acc = ~a;
    endcase
    e.n = e.acc[3];
    e.z = (e.acc == 4'h0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("acc", acc, e.acc);
        check("c", c, e.c);
        check("n", n, e.n);
        check("z", z, e.z);
        check("v", v, e.v);
        check("done_latency", cyc - e.acyc, e.lat);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // hold=1 keeps in_valid high with different op/operand for two busy cycles
  task automatic issue(input logic [2:0] o, input logic [3:0] b, input bit hold);
    exp_t       e;
    logic [3:0] a_before;
    int         k;
    k = 0;
    while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
    check("ready_wait", in_ready, 1);
    check("acc_pre", acc, m_acc);
    in_valid = 1'b1; op = o; operand = b;
    @(posedge clk); #1;
    e = model(m_acc, o, b);
    e.acyc = cyc;
    sb_q.push_back(e);
    a_before = m_acc;
    m_acc = e.acc;
    if (hold) begin op = ~o; operand = ~b; end
    else in_valid = 1'b0;
    k = 0;
    while (sb_q.size() != 0 && k < 10) begin
      if (busy) begin
        check("ready_busy", in_ready, 0);
        check("acc_hold", acc, a_before);
      end
      if (hold && k == 2) in_valid = 1'b0;
      @(posedge clk); #1; k++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 0, 1);
      sb_q.delete();
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; in_valid = 1'b0; op = '0; operand = '0; m_acc = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", acc, 0);
    check("rst_z", z, 1);
    check("rst_cnv", {c, n, v}, 0);
    check("rst_done_busy", {done, busy}, 0);
    reset = 1'b0;
    #1;
    check("rst_ready", in_ready, 1);

    issue(3'd0, 4'h5, 0);   // LOAD 5
    issue(3'd5, 4'h3, 0);   // ADD 3 -> 8, n v
    issue(3'd6, 4'h8, 0);   // SUB 8 -> 0, c z
    issue(3'd0, 4'hA, 0);
    issue(3'd3, 4'hF, 0);   // XOR F -> 5
    issue(3'd0, 4'hF, 0);
    issue(3'd5, 4'h1, 1);   // ADD 1 -> 0, c z, in_valid held during SERIAL
    issue(3'd0, 4'h3, 0);
    issue(3'd6, 4'h5, 0);   // 3-5 -> E, borrow
    issue(3'd0, 4'h8, 0);
    issue(3'd6, 4'h1, 1);   // 8-1 -> 7, signed overflow
    issue(3'd1, 4'h6, 0);
    issue(3'd2, 4'h9, 0);
    issue(3'd4, 4'h3, 0);
    issue(3'd7, 4'h0, 0);
    issue(3'd0, 4'h6, 0);
    issue(3'd5, 4'h7, 0);   // 6+7 -> D, overflow

    // in_valid held during SERIAL, then reset at counter=2
    issue(3'd0, 4'h9, 0);
    in_valid = 1'b1; op = 3'd5; operand = 4'h4;
    @(posedge clk); #1;
    check("abort_accept_busy", busy, 1);
    op = 3'd0; operand = 4'h2;
    repeat (2) begin
      check("abort_ready", in_ready, 0);
      check("abort_acc_hold", acc, 4'h9);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("abort_acc", acc, 0);
    check("abort_z", z, 1);
    check("abort_done_busy", {done, busy}, 0);
    in_valid = 1'b0;
    m_acc = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_ready_rel", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done_ready", in_ready, 1);
    issue(3'd5, 4'h3, 0);   // carry must be cleared: 0+3 -> 3
    issue(3'd6, 4'h1, 0);   // 3-1 -> 2

    repeat (2) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu4_acc.md
ALU4_ACC -- requirements
Module: alu4_acc

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk, reset.
REQ-002 Ports, in order: name  direction  width  meaning:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- op  input  3  opcode, sampled at accept
- operand  input  4  B operand, sampled at accept
- acc  output  4  accumulator, the A operand and the result
- c, n, z, v  output  1 each  carry, negative, zero and overflow flags
- done  output  1  one-cycle completion pulse
- busy  output  1  operation in progress
REQ-003 Opcodes SHALL be:
- 000 LOAD
- 001 AND
- 010 OR
- 011 XOR
- 100 XNOR
- 101 ADD
- 110 SUB (acc - operand)
- 111 NOT (~acc; operand ignored)

Function
REQ-004 FSM states SHALL be IDLE, LOGIC, SERIAL and DONE.
REQ-005 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
- in_ready=1 only in IDLE.
- busy=1 in LOGIC and SERIAL.
REQ-006 On accept, op and operand SHALL be latched internally.
- Later input changes SHALL NOT affect the running operation.
- in_valid outside IDLE SHALL be ignored; no queueing.
REQ-007 Non-arithmetic ops (LOAD, AND, OR, XOR, XNOR, NOT) SHALL go IDLE->LOGIC.
- acc and flags are written on the next edge, which also enters DONE.
- done is high exactly 1 cycle after the accept edge.
REQ-008 ADD and SUB SHALL go IDLE->SERIAL and compute bit-serially, LSB first, one bit per edge.
- 2-bit counter runs 0..3.
- Sum bits go into a 4-bit shift register.
- Carry register is initialised to 0 for ADD and 1 for SUB; SUB uses ~operand.
REQ-009 On the 4th SERIAL edge, acc and flags SHALL be written and the FSM SHALL enter DONE.
- done is high exactly 4 cycles after the accept edge.
REQ-010 acc and flags SHALL hold their previous values throughout SERIAL; no partial results are visible.
REQ-011 DONE SHALL last one cycle with done=1, then return to IDLE.
- done=0 in all other states.
- Accept is possible at the earliest on the edge that leaves DONE.
REQ-012 Flag rules on every write:
- z=(acc_new==0)
- n=acc_new[3]
REQ-013 ADD/SUB flag rules:
- c = carry out of bit 3; for SUB, c=1 means no borrow.
- v=1 when both effective operands share a sign bit that differs from the result sign.
REQ-014 LOAD, logic ops and NOT SHALL clear c and v.
REQ-015 All arithmetic SHALL be modulo 16; carry out of bit 3 goes only to c.

Reset
REQ-016 While reset=1, regardless of clk, the block SHALL force:
- state to IDLE
- acc to 4'h0
- c, n and v to 0
- z to 1
- done and busy to 0
- in_ready to 1, once reset is released
REQ-017 Reset during LOGIC or SERIAL SHALL abort the operation.
- No result is written, no done pulse is produced, and the counter and carry registers are cleared.

Verification
REQ-018 Bench SHALL cover these directed scenarios:
- Reset pulse -> acc=0, z=1, c=n=v=0, in_ready=1, busy=0.
- LOAD 5, then ADD 3 -> acc=8, n=1, v=1, c=0, z=0; done exactly 4 cycles after the ADD accept; acc stays 5 during SERIAL.
- acc=8, SUB 8 -> acc=0, z=1, c=1, v=0, n=0.
- acc=A, XOR F -> acc=5, c=v=0, z=0; done 1 cycle after accept.
- acc=F, ADD 1 -> acc=0, c=1, z=1, v=0.
- in_valid held high with new op/operand during SERIAL -> ignored, in_ready=0; then reset asserted at counter=2 -> acc=0, z=1 immediately, no done pulse, in_ready=1 after release.
